// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter_ctrl programmable timer block.
// Imported by the controller and by its counting datapath.
package counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_ctrl_core.sv
// Counting datapath for counter_ctrl: a WIDTH-bit up-counter with enable,
// synchronous clear and asynchronous active-low reset. Arithmetic wraps modulo 2^WIDTH.
module counter_core
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear takes priority so a periodic reload never races an increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_ctrl.sv
// Programmable one-shot/periodic timer: IDLE/RUN/PAUSE sequencing,
// terminal-count tick, sticky irq and overrun flags.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic             periodic_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             irq_ack_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             irq_o,
  output logic             overrun_o
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_limit;
  logic             r_periodic;
  logic             r_busy;
  logic             r_tick;
  logic             r_irq;
  logic             r_overrun;
  logic [WIDTH-1:0] w_count;
  logic             w_terminal;
  logic             w_count_en;
  logic             w_count_clr;
  logic             w_capture;

  counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk    (clock_i),
    .i_rst_n  (reset_n_i),
    .i_clear  (w_count_clr),
    .i_enable (w_count_en),
    .o_count  (w_count)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Priority inside RUN: stop, then pause, then terminal count, then increment.
  always_comb begin
    w_next_state = r_state;
    w_terminal   = 1'b0;
    w_count_en   = 1'b0;
    w_count_clr  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i && (limit_i != '0)) begin
          w_next_state = ST_RUN;
          w_capture    = 1'b1;
          w_count_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          w_next_state = ST_IDLE;
        end else if (pause_i) begin
          w_next_state = ST_PAUSE;
        end else if (w_count == r_limit) begin
          w_terminal = 1'b1;
          if (r_periodic) begin
            w_count_clr = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_count_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          w_next_state = ST_IDLE;
        end else if (!pause_i) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_limit    <= '0;
      r_periodic <= 1'b0;
    end else if (w_capture) begin
      r_limit    <= limit_i;
      r_periodic <= periodic_i;
    end
  end

  // A new terminal event beats a same-cycle ack; ack only clears when no event lands.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_busy    <= 1'b0;
      r_tick    <= 1'b0;
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_tick <= w_terminal;
      if (w_terminal) begin
        r_irq <= 1'b1;
        if (r_irq && !irq_ack_i) begin
          r_overrun <= 1'b1;
        end
      end else if (irq_ack_i) begin
        r_irq     <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign busy_o    = r_busy;
  assign count_o   = w_count;
  assign tick_o    = r_tick;
  assign irq_o     = r_irq;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized and directed bench for counter_ctrl, checked cycle by cycle
// against a behavioural timer model.
module tb_counter_ctrl;

  localparam int W = 4;

  logic         clock_i;
  logic         reset_n_i;
  logic         start_i;
  logic         stop_i;
  logic         pause_i;
  logic         periodic_i;
  logic [W-1:0] limit_i;
  logic         irq_ack_i;
  logic         busy_o;
  logic [W-1:0] count_o;
  logic         tick_o;
  logic         irq_o;
  logic         overrun_o;

  int vectors;
  int miscompares;

  bit mRunning;
  bit mPaused;
  int mCount;
  int mLimit;
  bit mPeriodic;
  bit mTick;
  bit mIrq;
  bit mOverrun;

  counter_ctrl #(
    .WIDTH (W)
  ) dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .pause_i    (pause_i),
    .periodic_i (periodic_i),
    .limit_i    (limit_i),
    .irq_ack_i  (irq_ack_i),
    .busy_o     (busy_o),
    .count_o    (count_o),
    .tick_o     (tick_o),
    .irq_o      (irq_o),
    .overrun_o  (overrun_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mRunning  = 1'b0;
    mPaused   = 1'b0;
    mCount    = 0;
    mLimit    = 0;
    mPeriodic = 1'b0;
    mTick     = 1'b0;
    mIrq      = 1'b0;
    mOverrun  = 1'b0;
  endtask

  // One clock of timer behaviour, expressed as what the timer does rather than how.
  task automatic modelStep(input bit st, input bit sp, input bit pa, input bit per,
                           input int lim, input bit ack);
    bit fired;
    fired = 1'b0;
    if (!mRunning) begin
      if (st && !sp && lim != 0) begin
        mRunning  = 1'b1;
        mPaused   = 1'b0;
        mCount    = 0;
        mLimit    = lim;
        mPeriodic = per;
      end
    end else if (sp) begin
      mRunning = 1'b0;
      mPaused  = 1'b0;
    end else if (mPaused) begin
      mPaused = pa;
    end else if (pa) begin
      mPaused = 1'b1;
    end else if (mCount == mLimit) begin
      fired = 1'b1;
      if (mPeriodic) mCount = 0;
      else mRunning = 1'b0;
    end else begin
      mCount = (mCount + 1) % (1 << W);
    end
    mTick = fired;
    if (fired) begin
      if (mIrq && !ack) mOverrun = 1'b1;
      mIrq = 1'b1;
    end else if (ack) begin
      mIrq     = 1'b0;
      mOverrun = 1'b0;
    end
  endtask

  task automatic checkModel();
    checkOutput("busy", busy_o, mRunning);
    checkOutput("count", count_o, mCount);
    checkOutput("tick", tick_o, mTick);
    checkOutput("irq", irq_o, mIrq);
    checkOutput("overrun", overrun_o, mOverrun);
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit pa, input bit per,
                               input int lim, input bit ack);
    start_i    = st;
    stop_i     = sp;
    pause_i    = pa;
    periodic_i = per;
    limit_i    = lim[W-1:0];
    irq_ack_i  = ack;
    modelStep(st, sp, pa, per, lim, ack);
    @(posedge clock_i);
    #1;
    checkModel();
  endtask

  task automatic idleSteps(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Reset is asserted away from any clock edge to show it acts without one.
  task automatic resetDut();
    start_i    = 1'b0;
    stop_i     = 1'b0;
    pause_i    = 1'b0;
    periodic_i = 1'b0;
    limit_i    = '0;
    irq_ack_i  = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_tick", tick_o, 0);
    checkOutput("rst_irq", irq_o, 0);
    checkOutput("rst_overrun", overrun_o, 0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pauseLevel;
    int lim;
    vectors     = 0;
    miscompares = 0;
    reset_n_i   = 1'b1;
    modelReset();
    resetDut();

    // Periodic limit 3: count 0,1,2,3,0 with a tick on every wrap.
    applyStimulus(1, 0, 0, 1, 3, 0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("p3_count", count_o, k % 4);
      checkOutput("p3_tick", tick_o, (k % 4) == 0);
      checkOutput("p3_busy", busy_o, 1);
    end
    applyStimulus(0, 1, 0, 0, 0, 1);

    // One-shot limit 5 ends with one tick, irq set and busy dropped together.
    applyStimulus(1, 0, 0, 0, 5, 0);
    idleSteps(6);
    checkOutput("os_count", count_o, 5);
    checkOutput("os_tick", tick_o, 1);
    checkOutput("os_busy", busy_o, 0);
    checkOutput("os_irq", irq_o, 1);
    idleSteps(2);
    checkOutput("os_tick_once", tick_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("os_ack", irq_o, 0);

    // Periodic limit 1: second tick without ack raises overrun; ack on third keeps both.
    applyStimulus(1, 0, 0, 1, 1, 0);
    idleSteps(4);
    checkOutput("ov_set", overrun_o, 1);
    idleSteps(1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ov_ack_tick", tick_o, 1);
    checkOutput("ov_ack_irq", irq_o, 1);
    checkOutput("ov_ack_ovr", overrun_o, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ov_clear", overrun_o, 0);

    // Pause at 4 for three cycles, then stop exactly at the terminal count.
    applyStimulus(1, 0, 0, 1, 7, 0);
    idleSteps(4);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("pz_hold", count_o, 4);
    idleSteps(2);
    checkOutput("pz_resume", count_o, 5);
    idleSteps(2);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pz_stop_count", count_o, 7);
    checkOutput("pz_stop_tick", tick_o, 0);
    checkOutput("pz_stop_busy", busy_o, 0);

    // Zero limit is refused, start with stop is refused.
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("z_busy", busy_o, 0);
    applyStimulus(1, 1, 0, 1, 3, 0);
    checkOutput("ss_busy", busy_o, 0);

    // Reset mid-run at count 2, then full-range wrap 15->0.
    applyStimulus(1, 0, 0, 1, 9, 0);
    idleSteps(2);
    checkOutput("mr_count", count_o, 2);
    resetDut();
    applyStimulus(1, 0, 0, 1, 15, 0);
    idleSteps(15);
    checkOutput("wr_15", count_o, 15);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("wr_0", count_o, 0);
    checkOutput("wr_tick", tick_o, 1);
    idleSteps(16);
    checkOutput("wr_period", tick_o, 1);

    // Randomized traffic with pause held as a level.
    pauseLevel = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        resetDut();
        pauseLevel = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) pauseLevel = ~pauseLevel;
      lim = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0, pauseLevel,
                    $urandom_range(0, 1) == 1, lim, $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, count/limit width in bits (legal 2..16).
REQ-002 clock_i  in  1  single clock, all state updates on rising edge.
REQ-003 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  single-cycle start request, honoured only in IDLE.
REQ-005 stop_i  in  1  single-cycle stop request, honoured in RUN or PAUSE.
REQ-006 pause_i  in  1  level, freezes counting while high in RUN/PAUSE.
REQ-007 periodic_i  in  1  sampled with start_i: 1 = periodic reload, 0 = one-shot.
REQ-008 limit_i  in  WIDTH  terminal count, sampled with start_i.
REQ-009 irq_ack_i  in  1  single-cycle clear of irq_o and overrun_o.
REQ-010 busy_o  out  1  high when state is not IDLE.
REQ-011 count_o  out  WIDTH  registered current count.
REQ-012 tick_o  out  1  one-cycle pulse per terminal-count event.
REQ-013 irq_o  out  1  sticky terminal-count flag.
REQ-014 overrun_o  out  1  sticky flag: terminal count while irq_o still pending.

Function
REQ-015 FSM states IDLE, RUN, PAUSE; all outputs registered.
REQ-016 IDLE + start_i=1 + limit_i!=0: capture limit_i and periodic_i, count_o<=0, state<=RUN next edge.
REQ-017 IDLE + start_i=1 + limit_i=0: request ignored, state stays IDLE, count_o unchanged.
REQ-018 RUN, no stop/pause: count_o<=count_o+1 each cycle while count_o != captured limit.
REQ-019 RUN, count_o == limit: tick_o<=1 for exactly one cycle, irq_o<=1.
REQ-020 Periodic terminal: count_o<=0, remain RUN; period = limit+1 cycles.
REQ-021 One-shot terminal: count_o holds limit, state<=IDLE, busy_o low in same cycle as tick_o high.
REQ-022 RUN + pause_i=1: state<=PAUSE, count_o frozen; PAUSE + pause_i=0: state<=RUN, counting resumes from frozen value.
REQ-023 stop_i in RUN/PAUSE: state<=IDLE, count_o holds; stop_i beats pause_i and terminal (no tick, no irq).
REQ-024 start_i in RUN/PAUSE ignored; start_i and stop_i together in IDLE: stay IDLE.
REQ-025 irq_o set wins over irq_ack_i in same cycle; ack alone clears irq_o and overrun_o.
REQ-026 overrun_o set when terminal event occurs with irq_o=1 and irq_ack_i=0; set wins over ack.
REQ-027 limit = 2^WIDTH-1 legal; count arithmetic is modulo 2^WIDTH, no carry output.

Reset
REQ-028 reset_n_i low: state=IDLE, count_o=0, busy_o=0, tick_o=0, irq_o=0, overrun_o=0, captured limit=0, captured mode=0, immediately and without clock.
REQ-029 Reset mid-RUN aborts silently: no tick_o, no irq_o on release; first edge after release is IDLE behaviour.

Structure
REQ-030 Shared package counter_ctrl_pkg holds the state enum type and default WIDTH constant.
REQ-031 One sub-module counter_core: WIDTH-bit register with enable, synchronous clear, async active-low reset; FSM and flags stay in counter_ctrl.

Verification
REQ-032 Reset, start_i with limit_i=3, periodic_i=1 -> count_o 0,1,2,3,0,1..., tick_o high every 4th cycle, busy_o=1 throughout.
REQ-033 One-shot limit_i=5 -> count_o stops at 5, single tick_o, irq_o=1, busy_o=0; irq_ack_i clears irq_o next cycle.
REQ-034 Periodic limit_i=1, no ack -> second tick_o sets overrun_o=1; ack in same cycle as third tick -> irq_o stays 1, overrun_o stays 1.
REQ-035 Periodic limit_i=7, pause_i high at count 4 for 3 cycles -> count_o holds 4, resumes 5; stop_i at count 7 -> IDLE, no tick, count_o=7.
REQ-036 start_i with limit_i=0 -> busy_o stays 0; reset_n_i low mid-RUN at count 2 -> all outputs 0 asynchronously.
REQ-037 WIDTH=4, limit_i=15 periodic -> count wraps 15->0 with tick_o, period 16 cycles.
